pipe_hazard_ctrl: RTL and testbench

- Sequencing controller for the 5-stage pipelined ARM datapath.
- Drives the enable and synchronous-clear (flush) inputs of the PC register and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB), all built from enable-capable flopr variants.
- Resolves load-use stalls, taken-branch flushes and multi-cycle data-memory waits.
- Halts the pipeline on a memory timeout.

---
 rtl/pipe_hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes, data-memory waits, timeout halt.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int TO_W        = 8,
  parameter int MEM_TIMEOUT = 200,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rm,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_pcsrc,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [REG_W-1:0] XZR       = REG_W'(31);
  localparam logic [TO_W-1:0]  TIMEOUT_V = TO_W'(MEM_TIMEOUT);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [TO_W-1:0] wait_cnt;
  logic [TO_W-1:0] wait_cnt_nxt;
  logic            mem_err_q;
  logic            luh;
  logic            resolve;

  assign luh = ex_memread & (ex_rd != XZR) &
               ((ex_rd == id_rn) | (id_uses_rm & (ex_rd == id_rm)));

  // Outputs are Mealy so a hazard takes effect in the cycle it is seen; everything is 0 in reset.
  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmem_en     = 1'b0;
    memwb_en     = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    resolve      = 1'b0;

    if (reset) begin
      case (state)
        S_RUN: begin
          if (dmem_req && !dmem_ready) begin
            state_nxt    = S_WAIT;
            wait_cnt_nxt = TO_W'(1);
          end else begin
            resolve = 1'b1;
          end
        end
        S_WAIT: begin
          if (dmem_ready) begin
            resolve      = 1'b1;
            state_nxt    = S_RUN;
            wait_cnt_nxt = '0;
          end else if (wait_cnt == TIMEOUT_V) begin
            state_nxt = S_HALT;
          end else begin
            wait_cnt_nxt = wait_cnt + TO_W'(1);
          end
        end
        S_HALT: begin
          state_nxt = S_HALT;
        end
        default: begin
          state_nxt    = S_RUN;
          wait_cnt_nxt = '0;
        end
      endcase

      // A taken branch squashes everything younger, so it outranks a load-use bubble.
      if (resolve) begin
        if (mem_pcsrc) begin
          pc_en       = 1'b1;
          ifid_en     = 1'b1;
          idex_en     = 1'b1;
          exmem_en    = 1'b1;
          memwb_en    = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
        end else if (luh) begin
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
          idex_flush = 1'b1;
        end else begin
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_RUN;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state_nxt == S_HALT) begin
        mem_err_q <= 1'b1;
      end
    end
  end

  assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic             stall_evt;
  logic             flush_evt;

  // ifid_flush is only ever raised by the taken-branch case, so it doubles as the flush event.
  assign stall_evt = reset & (state != S_HALT) & ~pc_en;
  assign flush_evt = ifid_flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_evt && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (flush_evt && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: constant vector table, hand-built wait/timeout
// sequences, and a randomized run against a rule-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 5;

  localparam logic [7:0] ACT_OFF    = 8'b00000_000;
  localparam logic [7:0] ACT_GO     = 8'b11111_000;
  localparam logic [7:0] ACT_BUBBLE = 8'b00111_010;
  localparam logic [7:0] ACT_FLUSH  = 8'b11111_111;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rn, id_rm, ex_rd;
  logic        id_uses_rm, ex_memread, mem_pcsrc, dmem_req, dmem_ready;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, mem_err;
  logic [31:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(
    .REG_W(5), .TO_W(8), .MEM_TIMEOUT(TIMEOUT), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .mem_pcsrc(mem_pcsrc),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [4:0] rn;
    logic [4:0] rm;
    logic       usesRm;
    logic       memread;
    logic [4:0] rd;
    logic       pcsrc;
    logic       req;
    logic       ready;
  } stim_t;

  typedef struct {
    string      name;
    stim_t      s;
    logic [7:0] want;
  } vec_t;

  int compared = 0;
  int mismatched = 0;

  // Reference model: 0 = running, 1 = waiting on memory, 2 = halted
  int          mMode = 0;
  int          mWaited = 0;
  logic        mErr = 1'b0;
  logic [31:0] mStalls = '0;
  logic [31:0] mFlushes = '0;

  function automatic stim_t mk(logic rst, logic [4:0] rn, logic [4:0] rm, logic usesRm,
                               logic memread, logic [4:0] rd, logic pcsrc, logic req, logic ready);
    stim_t s;
    s = '{rst, rn, rm, usesRm, memread, rd, pcsrc, req, ready};
    return s;
  endfunction

  function automatic logic [31:0] expCnt(logic [31:0] v);
`ifdef HAZARD_PERF_CNT_EN
    return v;
`else
    return (v & 32'h0);
`endif
  endfunction

  function automatic logic [7:0] decide();
    bit loadUse;
    loadUse = ex_memread && (ex_rd != 5'd31) &&
              ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));
    if (mem_pcsrc) return ACT_FLUSH;
    if (loadUse) return ACT_BUBBLE;
    return ACT_GO;
  endfunction

  task automatic compare(input string name, input logic [63:0] got, input logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    reset      = s.rst;
    id_rn      = s.rn;
    id_rm      = s.rm;
    id_uses_rm = s.usesRm;
    ex_memread = s.memread;
    ex_rd      = s.rd;
    mem_pcsrc  = s.pcsrc;
    dmem_req   = s.req;
    dmem_ready = s.ready;
  endtask

  // Samples outputs mid-cycle, checks against the model (and an optional constant), then
  // advances the model and the clock to just after the next rising edge.
  task automatic checkOutput(input string name, input bit haveWant, input logic [7:0] want);
    logic [7:0] exp;
    logic [7:0] got;
    @(negedge clk);
    if (!reset) begin
      mMode = 0; mWaited = 0; mErr = 1'b0; mStalls = '0; mFlushes = '0;
      exp = ACT_OFF;
    end else if (mMode == 2) begin
      exp = ACT_OFF;
    end else if (mMode == 1) begin
      exp = dmem_ready ? decide() : ACT_OFF;
    end else begin
      exp = (dmem_req && !dmem_ready) ? ACT_OFF : decide();
    end
    got = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush};
    compare({name, "/ctl"}, 64'(got), 64'(exp));
    if (haveWant) compare({name, "/ctl_const"}, 64'(got), 64'(want));
    compare({name, "/mem_err"}, 64'(mem_err), 64'(mErr));
    compare({name, "/stall_cnt"}, 64'(stall_cnt), 64'(expCnt(mStalls)));
    compare({name, "/flush_cnt"}, 64'(flush_cnt), 64'(expCnt(mFlushes)));
    if (reset) begin
      if (mMode != 2 && !exp[7] && mStalls != 32'hFFFF_FFFF) mStalls++;
      if (exp == ACT_FLUSH && mFlushes != 32'hFFFF_FFFF) mFlushes++;
      if (mMode == 0) begin
        if (dmem_req && !dmem_ready) begin
          mMode = 1; mWaited = 1;
        end
      end else if (mMode == 1) begin
        if (dmem_ready) mMode = 0;
        else if (mWaited == TIMEOUT) begin
          mMode = 2; mErr = 1'b1;
        end else mWaited++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkRegs(input string name, input logic wantErr, input logic [31:0] wantStall,
                           input logic [31:0] wantFlush);
    compare({name, "/err_const"}, 64'(mem_err), 64'(wantErr));
    compare({name, "/stall_const"}, 64'(stall_cnt), 64'(wantStall));
    compare({name, "/flush_const"}, 64'(flush_cnt), 64'(wantFlush));
  endtask

  task automatic pulseReset();
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("rst", 1, ACT_OFF);
  endtask

  vec_t table_v[$];

  initial begin
    stim_t idle;
    stim_t s;
    idle = mk(1, 5'd1, 5'd2, 0, 0, 5'd9, 0, 0, 0);

    table_v.push_back('{"idle",       mk(1, 1, 2, 0, 0, 9, 0, 0, 0),  ACT_GO});
    table_v.push_back('{"luh_rn",     mk(1, 3, 7, 0, 1, 3, 0, 0, 0),  ACT_BUBBLE});
    table_v.push_back('{"xzr_rn",     mk(1, 31, 7, 0, 1, 31, 0, 0, 0), ACT_GO});
    table_v.push_back('{"luh_rm",     mk(1, 5, 4, 1, 1, 4, 0, 0, 0),  ACT_BUBBLE});
    table_v.push_back('{"rm_unused",  mk(1, 5, 4, 0, 1, 4, 0, 0, 0),  ACT_GO});
    table_v.push_back('{"no_load",    mk(1, 6, 6, 1, 0, 6, 0, 0, 0),  ACT_GO});
    table_v.push_back('{"luh_x0",     mk(1, 0, 8, 0, 1, 0, 0, 0, 0),  ACT_BUBBLE});
    table_v.push_back('{"br_luh",     mk(1, 3, 7, 0, 1, 3, 1, 0, 0),  ACT_FLUSH});
    table_v.push_back('{"req_rdy_lu", mk(1, 2, 2, 1, 1, 2, 0, 1, 1),  ACT_BUBBLE});
    table_v.push_back('{"req_rdy_br", mk(1, 2, 9, 0, 0, 1, 1, 1, 1),  ACT_FLUSH});
    table_v.push_back('{"xzr_rm",     mk(1, 5, 31, 1, 1, 31, 0, 0, 0), ACT_GO});

    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;

    // Reset held for three cycles, then released
    repeat (3) checkOutput("reset_hold", 1, ACT_OFF);
    applyStimulus(idle);
    checkOutput("release", 1, ACT_GO);
    checkRegs("release", 1'b0, 32'd0, 32'd0);

    // Load-use stall, then the same with XZR
    pulseReset();
    applyStimulus(mk(1, 3, 0, 0, 1, 3, 0, 0, 0));
    checkOutput("luh", 1, ACT_BUBBLE);
    checkRegs("luh", 1'b0, expCnt(32'd1), 32'd0);
    applyStimulus(mk(1, 31, 0, 0, 1, 31, 0, 0, 0));
    checkOutput("luh_xzr", 1, ACT_GO);
    checkRegs("luh_xzr", 1'b0, expCnt(32'd1), 32'd0);

    // Branch beats a concurrent load-use hazard
    pulseReset();
    applyStimulus(mk(1, 3, 0, 0, 1, 3, 1, 0, 0));
    checkOutput("br_over_luh", 1, ACT_FLUSH);
    checkRegs("br_over_luh", 1'b0, 32'd0, expCnt(32'd1));

    // Four-cycle memory wait completing with a taken branch
    pulseReset();
    applyStimulus(mk(1, 1, 2, 0, 0, 9, 0, 1, 0));
    repeat (4) checkOutput("memwait", 1, ACT_OFF);
    applyStimulus(mk(1, 1, 2, 0, 0, 9, 1, 1, 1));
    checkOutput("memwait_done", 1, ACT_FLUSH);
    checkRegs("memwait_done", 1'b0, expCnt(32'd4), expCnt(32'd1));
    applyStimulus(idle);
    checkOutput("memwait_run", 1, ACT_GO);

    // Timeout into HALT, then recovery through reset
    pulseReset();
    applyStimulus(mk(1, 1, 2, 0, 0, 9, 0, 1, 0));
    repeat (TIMEOUT) checkOutput("timeout_wait", 1, ACT_OFF);
    checkRegs("timeout_pre", 1'b0, expCnt(32'(TIMEOUT)), 32'd0);
    checkOutput("timeout_last", 1, ACT_OFF);
    checkRegs("timeout_halt", 1'b1, expCnt(32'(TIMEOUT + 1)), 32'd0);
    applyStimulus(mk(1, 1, 2, 0, 0, 9, 1, 1, 1));
    repeat (2) checkOutput("halted", 1, ACT_OFF);
    checkRegs("halted", 1'b1, expCnt(32'(TIMEOUT + 1)), 32'd0);
    pulseReset();
    checkRegs("halt_reset", 1'b0, 32'd0, 32'd0);
    applyStimulus(idle);
    checkOutput("halt_recover", 1, ACT_GO);

    // Constant vector table, all applied from RUN
    pulseReset();
    for (int i = 0; i < table_v.size(); i++) begin
      applyStimulus(table_v[i].s);
      checkOutput(table_v[i].name, 1, table_v[i].want);
    end

    // Randomized run against the reference model
    for (int i = 0; i < 800; i++) begin
      s.rst     = (mMode == 2) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 49) != 0);
      s.rn      = 5'($urandom_range(0, 4));
      s.rm      = 5'($urandom_range(0, 4));
      s.usesRm  = 1'($urandom_range(0, 1));
      s.memread = 1'($urandom_range(0, 1));
      s.rd      = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 4));
      s.pcsrc   = ($urandom_range(0, 7) == 0);
      s.req     = ($urandom_range(0, 2) == 0);
      s.ready   = (mMode == 1) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 6);
      applyStimulus(s);
      checkOutput("random", 0, ACT_OFF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
